// File: rtl/pc_gen_unit_if.sv
// Fetch PC generator interface: stall/redirect requests in, fetch PC and status out.
// Macro PC_REDIR_CNT_EN adds the redirect counter output.
interface pc_gen_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REDIR = 3
);

  logic                      pc_write;
  logic [NUM_REDIR-1:0]      redir_valid;
  logic [NUM_REDIR*XLEN-1:0] redir_target;
  logic [XLEN-1:0]           pc;
  logic [XLEN-1:0]           pc_4;
  logic                      pend_valid;
  logic                      misalign_err;
  logic [XLEN-1:0]           misalign_addr;
`ifdef PC_REDIR_CNT_EN
  logic [31:0]               redir_cnt;
`endif

  // Pipeline control side drives requests and observes the PC.
  modport master (
    output pc_write,
    output redir_valid,
    output redir_target,
    input  pc,
    input  pc_4,
    input  pend_valid,
    input  misalign_err,
    input  misalign_addr
`ifdef PC_REDIR_CNT_EN
    , input redir_cnt
`endif
  );

  modport slave (
    input  pc_write,
    input  redir_valid,
    input  redir_target,
    output pc,
    output pc_4,
    output pend_valid,
    output misalign_err,
    output misalign_addr
`ifdef PC_REDIR_CNT_EN
    , output redir_cnt
`endif
  );

endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator with prioritised redirects, stall-time redirect buffering and
// misalignment flagging. Macro PC_REDIR_CNT_EN adds a saturating redirect counter.
module pc_gen_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     NUM_REDIR = 3
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_unit_if.slave    bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_valid_q, pend_valid_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            sel_valid;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] cand;
  logic            cand_redir;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Scan from the lowest priority upward so the lowest valid index is written last.
  always_comb begin
    sel_valid  = 1'b0;
    sel_target = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) begin
        sel_valid  = 1'b1;
        sel_target = bus.redir_target[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    cand       = pc_plus4;
    cand_redir = 1'b0;
    if (sel_valid) begin
      cand       = sel_target;
      cand_redir = 1'b1;
    end else if (pend_valid_q) begin
      cand       = pend_tgt_q;
      cand_redir = 1'b1;
    end
  end

  always_comb begin
    pc_d            = pc_q;
    pend_tgt_d      = pend_tgt_q;
    pend_valid_d    = pend_valid_q;
    misalign_err_d  = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (bus.pc_write) begin
      pc_d         = {cand[XLEN-1:2], 2'b00};
      pend_valid_d = 1'b0;
      if (cand_redir && (cand[1:0] != 2'b00)) begin
        misalign_err_d  = 1'b1;
        misalign_addr_d = cand;
      end
    end else if (sel_valid) begin
      // Latest stalled redirect wins over anything already buffered.
      pend_valid_d = 1'b1;
      pend_tgt_d   = sel_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_VEC;
      pend_tgt_q      <= '0;
      pend_valid_q    <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      pend_tgt_q      <= pend_tgt_d;
      pend_valid_q    <= pend_valid_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

`ifdef PC_REDIR_CNT_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    if (bus.pc_write && cand_redir && (redir_cnt_q != 32'hFFFF_FFFF)) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt_q <= '0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.redir_cnt = redir_cnt_q;
`endif

  assign bus.pc            = pc_q;
  assign bus.pc_4          = pc_plus4;
  assign bus.pend_valid    = pend_valid_q;
  assign bus.misalign_err  = misalign_err_q;
  assign bus.misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: per-cycle comparison against a behavioural model
// plus directed literal expectations.
module tb_pc_gen_unit;

  localparam logic [31:0] RstVec = 32'h0000_1000;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  bit   chk_en;

  pc_gen_unit_if #(.XLEN(32), .NUM_REDIR(3)) bus ();

  pc_gen_unit #(
    .XLEN      (32),
    .RESET_VEC (RstVec),
    .NUM_REDIR (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model of the fetch PC state.
  logic [31:0] m_pc, m_pend_tgt, m_addr, m_cnt, m_src;
  logic        m_pend, m_err, m_found, m_redir;
  logic [31:0] m_tgt;

  always @(posedge clk) begin
    if (rst) begin
      m_pc       = RstVec;
      m_pend     = 1'b0;
      m_pend_tgt = 32'h0;
      m_err      = 1'b0;
      m_addr     = 32'h0;
      m_cnt      = 32'h0;
    end else begin
      m_found = 1'b0;
      m_tgt   = 32'h0;
      for (int i = 0; i < 3; i++) begin
        if (!m_found && bus.redir_valid[i]) begin
          m_found = 1'b1;
          m_tgt   = bus.redir_target[i*32 +: 32];
        end
      end
      if (bus.pc_write) begin
        m_redir = m_found || m_pend;
        m_src   = m_found ? m_tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
        m_pc    = m_src & ~32'h3;
        m_pend  = 1'b0;
        m_err   = m_redir && (m_src % 4 != 0);
        if (m_err) m_addr = m_src;
        if (m_redir && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_err = 1'b0;
        if (m_found) begin
          m_pend     = 1'b1;
          m_pend_tgt = m_tgt;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", bus.pc, m_pc);
      check("model_pc_4", bus.pc_4, m_pc + 32'd4);
      check("model_pend_valid", {31'h0, bus.pend_valid}, {31'h0, m_pend});
      check("model_misalign_err", {31'h0, bus.misalign_err}, {31'h0, m_err});
      check("model_misalign_addr", bus.misalign_addr, m_addr);
`ifdef PC_REDIR_CNT_EN
      check("model_redir_cnt", bus.redir_cnt, m_cnt);
`endif
    end
  end

  task automatic step(input logic wr, input logic [2:0] v,
                      input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    bus.pc_write     = wr;
    bus.redir_valid  = v;
    bus.redir_target = {t2, t1, t0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;

    // 1: reset then sequential fetch
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    chk_en = 1'b1;
    check("reset_pc", bus.pc, 32'h0000_1000);
    check("reset_pend", {31'h0, bus.pend_valid}, 32'h0);
    check("reset_err", {31'h0, bus.misalign_err}, 32'h0);
    rst = 1'b0;
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("seq_pc1", bus.pc, 32'h0000_1004);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("seq_pc2", bus.pc, 32'h0000_1008);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("seq_pc3", bus.pc, 32'h0000_100C);
    check("seq_pc4_out", bus.pc_4, 32'h0000_1010);

    // 2: source 1 beats source 2
    step(1'b1, 3'b110, 32'h0, 32'h200, 32'h300);
    check("prio_pc", bus.pc, 32'h0000_0200);
    check("prio_pend", {31'h0, bus.pend_valid}, 32'h0);

    // 3: redirect during stall buffered, applied on release
    step(1'b0, 3'b100, 32'h0, 32'h0, 32'h400);
    check("stall_hold_pc", bus.pc, 32'h0000_0200);
    check("stall_pend", {31'h0, bus.pend_valid}, 32'h1);
    step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    check("stall_hold_pc2", bus.pc, 32'h0000_0200);
    check("stall_pend2", {31'h0, bus.pend_valid}, 32'h1);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("release_pc", bus.pc, 32'h0000_0400);
    check("release_pend", {31'h0, bus.pend_valid}, 32'h0);

    // 4: new redirect supersedes pending
    step(1'b0, 3'b100, 32'h0, 32'h0, 32'h400);
    step(1'b1, 3'b001, 32'h800, 32'h0, 32'h0);
    check("supersede_pc", bus.pc, 32'h0000_0800);
    check("supersede_pend", {31'h0, bus.pend_valid}, 32'h0);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("supersede_next", bus.pc, 32'h0000_0804);

    // newer stalled redirect overwrites older pending
    step(1'b0, 3'b010, 32'h0, 32'h600, 32'h0);
    step(1'b0, 3'b100, 32'h0, 32'h0, 32'h700);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("overwrite_pc", bus.pc, 32'h0000_0700);

    // all sources valid: source 0 wins
    step(1'b1, 3'b111, 32'h10, 32'h20, 32'h30);
    check("all_valid_pc", bus.pc, 32'h0000_0010);

    // 5: misaligned target
    step(1'b1, 3'b010, 32'h0, 32'h506, 32'h0);
    check("mis_pc", bus.pc, 32'h0000_0504);
    check("mis_err", {31'h0, bus.misalign_err}, 32'h1);
    check("mis_addr", bus.misalign_addr, 32'h0000_0506);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("mis_err_clear", {31'h0, bus.misalign_err}, 32'h0);
    check("mis_addr_hold", bus.misalign_addr, 32'h0000_0506);
    check("mis_next_pc", bus.pc, 32'h0000_0508);

    // 6: wrap, then reset while pending
    step(1'b1, 3'b001, 32'hFFFF_FFFC, 32'h0, 32'h0);
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_pc_4", bus.pc_4, 32'h0000_0000);
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("wrap_next", bus.pc, 32'h0000_0000);
    step(1'b0, 3'b001, 32'h40, 32'h0, 32'h0);
    check("pre_rst_pend", {31'h0, bus.pend_valid}, 32'h1);
    rst = 1'b1;
    step(1'b1, 3'b011, 32'h3, 32'h50, 32'h0);
    check("rst2_pc", bus.pc, 32'h0000_1000);
    check("rst2_pend", {31'h0, bus.pend_valid}, 32'h0);
    check("rst2_addr", bus.misalign_addr, 32'h0);
    check("rst2_err", {31'h0, bus.misalign_err}, 32'h0);
`ifdef PC_REDIR_CNT_EN
    check("rst2_cnt", bus.redir_cnt, 32'h0);
`endif
    rst = 1'b0;
    step(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    check("post_rst_pc", bus.pc, 32'h0000_1004);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
